matrix_axil_regs: RTL and testbench

//  AXI4-Lite slave register bank for the Matrix IP (S00_AXI port): 4 x 32-bit R/W operand registers.

---
 rtl/matrix_pkg.sv | 33 +++
 rtl/matrix_axil_regs.sv | 160 ++++++++++++++++
 tb/tb_matrix_axil_regs.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared types, register indices and the byte-strobe merge helper for the
// Matrix IP AXI4-Lite register bank.
package matrix_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   localparam int unsigned ADDR_LSB = 2;

   localparam logic [1:0] REG_IDX_A0 = 2'd0;
   localparam logic [1:0] REG_IDX_A1 = 2'd1;
   localparam logic [1:0] REG_IDX_A2 = 2'd2;
   localparam logic [1:0] REG_IDX_A3 = 2'd3;

   typedef logic [3:0][31:0] reg_bank_t;

   // Bytes with a clear strobe keep their old value; WSTRB=0 leaves the word untouched.
   function automatic logic [31:0] apply_strobe(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/matrix_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit operand registers to the matrix core,
// with independent AW/W skid slots and a single-outstanding read channel.
module matrix_axil_regs
   import matrix_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned NUM_REGS           = 2 ** (C_S_AXI_ADDR_WIDTH - ADDR_LSB)
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output reg_bank_t                         reg_q,
   output logic [NUM_REGS-1:0]               reg_wr_pulse
);

   localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_t;

   reg_bank_t  regs;

   logic                            aw_full;
   logic [IDX_W-1:0]                aw_idx;
   logic                            w_full;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;

   logic                            aw_hs;
   logic                            w_hs;
   logic                            commit;
   logic                            aw_full_nxt;
   logic                            w_full_nxt;
   logic                            bvalid_nxt;
   logic [IDX_W-1:0]                cm_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   cm_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] cm_strb;

   rd_state_t                       rd_state;
   logic [IDX_W-1:0]                ar_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rd_word;

   logic                            unused_ok;

   assign unused_ok   = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign S_AXI_BRESP = OKAY;
   assign S_AXI_RRESP = OKAY;
   assign reg_q       = regs;
   assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

   // A slot counts as full in the cycle its handshake lands, so AW and W
   // arriving together (or the second of the pair) commit on that same edge.
   always_comb begin
      aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
      w_hs        = S_AXI_WVALID & S_AXI_WREADY;
      commit      = (aw_full | aw_hs) & (w_full | w_hs);
      aw_full_nxt = (aw_full | aw_hs) & ~commit;
      w_full_nxt  = (w_full | w_hs) & ~commit;
      bvalid_nxt  = commit | (S_AXI_BVALID & ~S_AXI_BREADY);
      cm_idx      = aw_full ? aw_idx : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      cm_data     = w_full ? w_data : S_AXI_WDATA;
      cm_strb     = w_full ? w_strb : S_AXI_WSTRB;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         regs          <= '0;
         aw_full       <= 1'b0;
         aw_idx        <= '0;
         w_full        <= 1'b0;
         w_data        <= '0;
         w_strb        <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         reg_wr_pulse  <= '0;
      end else begin
         aw_full       <= aw_full_nxt;
         w_full        <= w_full_nxt;
         S_AXI_BVALID  <= bvalid_nxt;
         S_AXI_AWREADY <= ~aw_full_nxt & ~bvalid_nxt;
         S_AXI_WREADY  <= ~w_full_nxt & ~bvalid_nxt;
         reg_wr_pulse  <= '0;
         if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
         if (w_hs) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            regs[cm_idx]         <= apply_strobe(regs[cm_idx], cm_data, cm_strb);
            reg_wr_pulse[cm_idx] <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      case (ar_idx)
         REG_IDX_A0: rd_word = regs[REG_IDX_A0];
         REG_IDX_A1: rd_word = regs[REG_IDX_A1];
         REG_IDX_A2: rd_word = regs[REG_IDX_A2];
         REG_IDX_A3: rd_word = regs[REG_IDX_A3];
         default:    rd_word = '0;
      endcase
   end

   // rd_word samples regs before this edge's commit lands, so a colliding read sees the old value.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rd_state      <= RD_IDLE;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               S_AXI_ARREADY <= 1'b1;
               if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                  S_AXI_RDATA   <= rd_word;
                  S_AXI_RVALID  <= 1'b1;
                  S_AXI_ARREADY <= 1'b0;
                  rd_state      <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID  <= 1'b0;
                  S_AXI_ARREADY <= 1'b1;
                  rd_state      <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_axil_regs.sv
// Directed bench for matrix_axil_regs: write/read paths, strobes, stalls,
// read/write collision and reset mid-transaction.
module tb_matrix_axil_regs;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic [3:0]        S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [3:0]        S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;
   logic [3:0][31:0]  reg_q;
   logic [3:0]        reg_wr_pulse;

   int total = 0;
   int bad   = 0;
   int pulse_cnt [4] = '{default: 0};

   matrix_axil_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .NUM_REGS           (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   always #5 ACLK = ~ACLK;

   always @(negedge ACLK) begin
      for (int i = 0; i < 4; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int unsigned n;
      bit aw_done, w_done, aw_go, w_go;
      S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
      S_AXI_BREADY = 1'b1;
      aw_done = 1'b0; w_done = 1'b0; n = 0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
         w_go  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_go) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
         if (w_go)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
         n++;
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      check("wr_accept", 128'(aw_done && w_done), 128'd1);
      n = 0;
      while (!S_AXI_BVALID && n < 20) begin tick(); n++; end
      check("wr_bvalid", 128'(S_AXI_BVALID), 128'd1);
      check("wr_bresp", 128'(S_AXI_BRESP), 128'd0);
      tick();
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
      int unsigned n;
      bit go, done;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
      done = 1'b0; n = 0;
      while (!done && n < 20) begin
         go = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (go) begin S_AXI_ARVALID = 1'b0; done = 1'b1; end
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin tick(); n++; end
      check("rd_rvalid", 128'(S_AXI_RVALID), 128'd1);
      check("rd_rresp", 128'(S_AXI_RRESP), 128'd0);
      data = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int base;

      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      repeat (3) tick();

      check("rst_awready", 128'(S_AXI_AWREADY), 128'd0);
      check("rst_wready", 128'(S_AXI_WREADY), 128'd0);
      check("rst_bvalid", 128'(S_AXI_BVALID), 128'd0);
      check("rst_arready", 128'(S_AXI_ARREADY), 128'd0);
      check("rst_rvalid", 128'(S_AXI_RVALID), 128'd0);
      check("rst_rdata", 128'(S_AXI_RDATA), 128'd0);
      check("rst_reg_q", 128'(reg_q), 128'd0);
      check("rst_pulse", 128'(reg_wr_pulse), 128'd0);

      ARESET = 1'b0;
      tick();
      check("post_rst_awready", 128'(S_AXI_AWREADY), 128'd1);
      check("post_rst_wready", 128'(S_AXI_WREADY), 128'd1);
      check("post_rst_arready", 128'(S_AXI_ARREADY), 128'd1);

      // four plain writes, then read back
      axi_write(4'h0, 32'd1, 4'hF);
      axi_write(4'h4, 32'd2, 4'hF);
      axi_write(4'h8, 32'd3, 4'hF);
      axi_write(4'hC, 32'd4, 4'hF);
      axi_read(4'h0, rd); check("rd_a0", 128'(rd), 128'd1);
      axi_read(4'h4, rd); check("rd_a1", 128'(rd), 128'd2);
      axi_read(4'h8, rd); check("rd_a2", 128'(rd), 128'd3);
      axi_read(4'hC, rd); check("rd_a3", 128'(rd), 128'd4);
      check("reg_q_all", 128'(reg_q), {32'd4, 32'd3, 32'd2, 32'd1});

      // byte strobes, read via an address with nonzero low bits
      base = pulse_cnt[2];
      axi_write(4'h8, 32'hAABBCCDD, 4'hF);
      axi_write(4'h8, 32'h11223344, 4'b0101);
      axi_read(4'hB, rd);
      check("strobe_merge", 128'(rd), 128'hAA22CC44);
      check("strobe_pulses", 128'(pulse_cnt[2] - base), 128'd2);
      base = pulse_cnt[1];
      axi_write(4'h4, 32'hFFFFFFFF, 4'h0);
      check("strb0_reg", 128'(reg_q[1]), 128'd2);
      check("strb0_pulse", 128'(pulse_cnt[1] - base), 128'd1);

      // W leads AW by three cycles
      S_AXI_WDATA = 32'h000000C3; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      check("wfirst_wready", 128'(S_AXI_WREADY), 128'd1);
      tick();
      S_AXI_WVALID = 1'b0;
      check("wfirst_wready_drop", 128'(S_AXI_WREADY), 128'd0);
      tick();
      tick();
      check("wfirst_no_bvalid", 128'(S_AXI_BVALID), 128'd0);
      check("wfirst_reg_hold", 128'(reg_q[3]), 128'd4);
      S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
      check("wfirst_awready", 128'(S_AXI_AWREADY), 128'd1);
      tick();
      S_AXI_AWVALID = 1'b0;
      check("wfirst_bvalid", 128'(S_AXI_BVALID), 128'd1);
      check("wfirst_reg", 128'(reg_q[3]), 128'hC3);
      check("wfirst_pulse", 128'(reg_wr_pulse), 128'b1000);
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check("wfirst_bclear", 128'(S_AXI_BVALID), 128'd0);

      // BREADY withheld for ten cycles while the master keeps offering another write
      base = pulse_cnt[0];
      S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h00005A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      check("hold_ready_in", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'b11);
      tick();
      S_AXI_WDATA = 32'h0000DEAD;
      for (int i = 0; i < 10; i++) begin
         check("hold_bvalid", 128'(S_AXI_BVALID), 128'd1);
         check("hold_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'b00);
         tick();
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      check("hold_bclear", 128'(S_AXI_BVALID), 128'd0);
      check("hold_b2b_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'b11);
      check("hold_reg", 128'(reg_q[0]), 128'h5A5A);
      check("hold_once", 128'(pulse_cnt[0] - base), 128'd1);

      // read capture collides with write commit on register 1
      axi_write(4'h4, 32'd5, 4'hF);
      S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'd9; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
      check("coll_readys", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'b111);
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      check("coll_rvalid", 128'(S_AXI_RVALID), 128'd1);
      check("coll_rdata_old", 128'(S_AXI_RDATA), 128'd5);
      check("coll_bvalid", 128'(S_AXI_BVALID), 128'd1);
      check("coll_reg_new", 128'(reg_q[1]), 128'd9);
      S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
      axi_read(4'h4, rd);
      check("coll_reread", 128'(rd), 128'd9);

      // reset with an address parked in the AW slot
      S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      ARESET = 1'b1;
      tick();
      check("mid_rst_outs", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                                 S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, reg_wr_pulse}), 128'd0);
      check("mid_rst_rdata", 128'(S_AXI_RDATA), 128'd0);
      check("mid_rst_reg_q", 128'(reg_q), 128'd0);
      ARESET = 1'b0;
      tick();
      S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      check("orphan_wready", 128'(S_AXI_WREADY), 128'd1);
      tick();
      S_AXI_WVALID = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("orphan_no_bvalid", 128'(S_AXI_BVALID), 128'd0);
         check("orphan_reg_q", 128'(reg_q), 128'd0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
